// File: rtl/rom_access_arbiter.sv
// Arbitrates the fetch (F) and data-table (D) ports onto one single-port ROM and sequences cs/re.
// Define ROM_ARB_FIXED_PRIO_EN for fixed F-over-D priority; the default build is round-robin.
module rom_access_arbiter #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_f_req,
    input  logic [ADDR_WIDTH-1:0] i_f_addr,
    output logic                  o_f_ack,
    input  logic                  i_d_req,
    input  logic [ADDR_WIDTH-1:0] i_d_addr,
    output logic                  o_d_ack,
    output logic [WIDTH-1:0]      o_rdata,
    output logic                  o_busy,
    output logic [ADDR_WIDTH-1:0] o_rom_addr,
    output logic                  o_rom_cs,
    output logic                  o_rom_re,
    input  logic [WIDTH-1:0]      i_rom_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_DONE
    } state_t;

    localparam logic PORT_F = 1'b0;
    localparam logic PORT_D = 1'b1;

    state_t r_state;
    logic   r_served;
`ifndef ROM_ARB_FIXED_PRIO_EN
    logic   r_rr_last;
`endif

    logic                  w_f_elig;
    logic                  w_d_elig;
    logic                  w_grant;
    logic                  w_win;
    logic [ADDR_WIDTH-1:0] w_win_addr;

    // The port just acked still holds req in DONE, so it is masked to avoid a duplicate read.
    assign w_f_elig = i_f_req && !(r_state == S_DONE && r_served == PORT_F);
    assign w_d_elig = i_d_req && !(r_state == S_DONE && r_served == PORT_D);
    assign w_grant  = w_f_elig || w_d_elig;

`ifdef ROM_ARB_FIXED_PRIO_EN
    assign w_win = w_f_elig ? PORT_F : PORT_D;
`else
    assign w_win = (w_f_elig && w_d_elig) ? ~r_rr_last : (w_f_elig ? PORT_F : PORT_D);
`endif

    assign w_win_addr = (w_win == PORT_D) ? i_d_addr : i_f_addr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_served   <= PORT_F;
`ifndef ROM_ARB_FIXED_PRIO_EN
            r_rr_last  <= PORT_D;
`endif
            o_f_ack    <= 1'b0;
            o_d_ack    <= 1'b0;
            o_rdata    <= '0;
            o_busy     <= 1'b0;
            o_rom_addr <= '0;
            o_rom_cs   <= 1'b0;
            o_rom_re   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    o_f_ack <= 1'b0;
                    o_d_ack <= 1'b0;
                    if (w_grant) begin
                        o_rom_addr <= w_win_addr;
                        o_rom_cs   <= 1'b1;
                        o_busy     <= 1'b1;
                        r_served   <= w_win;
`ifndef ROM_ARB_FIXED_PRIO_EN
                        r_rr_last  <= w_win;
`endif
                        r_state    <= S_SETUP;
                    end else begin
                        o_rom_cs <= 1'b0;
                        o_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                S_SETUP: begin
                    o_rom_re <= 1'b1;
                    r_state  <= S_STROBE;
                end
                S_STROBE: begin
                    o_rdata  <= i_rom_data;
                    o_rom_re <= 1'b0;
                    if (r_served == PORT_F) begin
                        o_f_ack <= 1'b1;
                    end else begin
                        o_d_ack <= 1'b1;
                    end
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
